// File: rtl/alu_operand_stage_if.sv
// Handshake, writeback and decoded-operand bundle between the fetch side and
// the operand stage.
interface alu_operand_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_op;
  logic [31:0] out_rv1;
  logic [31:0] out_rv2;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  modport master (
    output in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, out_op, out_rv1, out_rv2, out_rd, out_we, out_illegal
  );

  modport slave (
    input  in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, out_op, out_rv1, out_rv2, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/alu_operand_stage.sv
// RV32I OP/OP-IMM decode, 32x32 register file and one-entry valid/ready slot
// that presents ALU op code and operands to the execute stage.
module alu_operand_stage #(
  parameter int unsigned RESET_PC_UNUSED = 0,
  parameter bit          BYPASS          = 1'b1
) (
  input logic               clk,
  input logic               reset,
  alu_operand_stage_if.slave bus
);

  if (RESET_PC_UNUSED != 0) begin : g_bad_param
    $error("RESET_PC_UNUSED must be 0");
  end

  typedef enum logic [5:0] {
    ALU_ADDI  = 6'h00, ALU_SLTI = 6'h01, ALU_SLTIU = 6'h02, ALU_XORI = 6'h03,
    ALU_ORI   = 6'h04, ALU_ANDI = 6'h05, ALU_SLLI  = 6'h06, ALU_SRLI = 6'h07,
    ALU_SRAI  = 6'h08, ALU_ADD  = 6'h09, ALU_SUB   = 6'h0A, ALU_SLL  = 6'h0B,
    ALU_SLT   = 6'h0C, ALU_SLTU = 6'h0D, ALU_XOR   = 6'h0E, ALU_SRL  = 6'h0F,
    ALU_SRA   = 6'h10, ALU_OR   = 6'h11, ALU_AND   = 6'h12, ALU_ILL  = 6'h3F
  } alu_op_e;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic [31:0] regs [32];
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] dec_rv1, dec_rv2;
  logic        dec_legal;
  alu_op_e     dec_op;

  assign opcode = bus.instr[6:0];
  assign rd     = bus.instr[11:7];
  assign f3     = bus.instr[14:12];
  assign rs1    = bus.instr[19:15];
  assign rs2    = bus.instr[24:20];
  assign f7     = bus.instr[31:25];

  assign bus.in_ready = !bus.out_valid || bus.out_ready;

  // Same-cycle writeback is forwarded so the captured operand sees the new value.
  always_comb begin
    rs1_val = '0;
    if (rs1 != 5'd0) begin
      if (BYPASS && bus.wb_en && bus.wb_rd == rs1) rs1_val = bus.wb_data;
      else                                         rs1_val = regs[rs1];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (rs2 != 5'd0) begin
      if (BYPASS && bus.wb_en && bus.wb_rd == rs2) rs2_val = bus.wb_data;
      else                                         rs2_val = regs[rs2];
    end
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = ALU_ILL;
    dec_rv1   = '0;
    dec_rv2   = '0;
    case (opcode)
      OPC_OPIMM: begin
        dec_legal = 1'b1;
        dec_rv2   = {{20{bus.instr[31]}}, bus.instr[31:20]};
        case (f3)
          3'b000: dec_op = ALU_ADDI;
          3'b010: dec_op = ALU_SLTI;
          3'b011: dec_op = ALU_SLTIU;
          3'b100: dec_op = ALU_XORI;
          3'b110: dec_op = ALU_ORI;
          3'b001: begin
            dec_op    = ALU_SLLI;
            dec_rv2   = {27'b0, rs2};
            dec_legal = (f7 == F7_ZERO);
          end
          3'b101: begin
            dec_rv2 = {27'b0, rs2};
            if (f7 == F7_ZERO)     dec_op = ALU_SRLI;
            else if (f7 == F7_ALT) dec_op = ALU_SRAI;
            else                   dec_legal = 1'b0;
          end
          default: dec_op = ALU_ANDI;
        endcase
      end
      OPC_OP: begin
        dec_legal = 1'b1;
        dec_rv2   = rs2_val;
        case ({f7, f3})
          {F7_ZERO, 3'b000}: dec_op = ALU_ADD;
          {F7_ALT,  3'b000}: dec_op = ALU_SUB;
          {F7_ZERO, 3'b001}: dec_op = ALU_SLL;
          {F7_ZERO, 3'b010}: dec_op = ALU_SLT;
          {F7_ZERO, 3'b011}: dec_op = ALU_SLTU;
          {F7_ZERO, 3'b100}: dec_op = ALU_XOR;
          {F7_ZERO, 3'b101}: dec_op = ALU_SRL;
          {F7_ALT,  3'b101}: dec_op = ALU_SRA;
          {F7_ZERO, 3'b110}: dec_op = ALU_OR;
          {F7_ZERO, 3'b111}: dec_op = ALU_AND;
          default:           dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
    // Illegal encodings present a zero-operand 3F op regardless of partial decode.
    if (dec_legal) begin
      dec_rv1 = rs1_val;
    end else begin
      dec_op  = ALU_ILL;
      dec_rv2 = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.out_op      <= '0;
      bus.out_rv1     <= '0;
      bus.out_rv2     <= '0;
      bus.out_rd      <= '0;
      bus.out_we      <= 1'b0;
      bus.out_illegal <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (bus.wb_en && bus.wb_rd != 5'd0) regs[bus.wb_rd] <= bus.wb_data;
      if (bus.in_valid && bus.in_ready) begin
        bus.out_valid   <= 1'b1;
        bus.out_op      <= dec_op;
        bus.out_rv1     <= dec_rv1;
        bus.out_rv2     <= dec_rv2;
        bus.out_rd      <= rd;
        bus.out_we      <= dec_legal && (rd != 5'd0);
        bus.out_illegal <= !dec_legal;
      end else if (bus.out_ready && bus.out_valid) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage: decode, register file, bypass,
// backpressure and reset behaviour with hand-computed expectations.
module tb_alu_operand_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage_if bus();

  alu_operand_stage #(.RESET_PC_UNUSED(0), .BYPASS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // {valid, op, rv1, rv2, rd, we, illegal}
  function automatic logic [77:0] obs();
    return {bus.out_valid, bus.out_op, bus.out_rv1, bus.out_rv2,
            bus.out_rd, bus.out_we, bus.out_illegal};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [77:0] exp;
    reset = 1'b1; bus.in_valid = 1'b1; bus.instr = 32'hFFB00093;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.out_ready = 1'b1;
    cyc();
    exp = '0;
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL reset_state got=%h want=%h", obs(), exp);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    reset = 1'b0;
    cyc();
    exp = {1'b1, 6'h00, 32'h0, 32'hFFFFFFFB, 5'd1, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL addi got=%h want=%h", obs(), exp);
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL drain_valid got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_sub();
    logic [77:0] exp;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'd7;
    cyc();
    bus.wb_rd = 5'd2; bus.wb_data = 32'd3;
    cyc();
    bus.wb_en = 1'b0; bus.in_valid = 1'b1; bus.instr = 32'h402081B3;
    cyc();
    exp = {1'b1, 6'h0A, 32'd7, 32'd3, 5'd3, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL sub got=%h want=%h", obs(), exp);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_bypass();
    logic [77:0] exp;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h10;
    bus.in_valid = 1'b1; bus.instr = 32'h00008233;
    cyc();
    exp = {1'b1, 6'h09, 32'h10, 32'h0, 5'd4, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL bypass got=%h want=%h", obs(), exp);
    end
    bus.wb_en = 1'b0;
    cyc();
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL bypass_reread got=%h want=%h", obs(), exp);
    end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [77:0] exp_a, exp_b;
    exp_a = {1'b1, 6'h00, 32'h0, 32'd1, 5'd5, 1'b1, 1'b0};
    exp_b = {1'b1, 6'h00, 32'h0, 32'd2, 5'd6, 1'b1, 1'b0};
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.instr = 32'h00100293;
    cyc();
    checks++;
    if (obs() !== exp_a) begin
      errors++; $display("FAIL stall_capture got=%h want=%h", obs(), exp_a);
    end
    bus.instr = 32'h00200313;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready[%0d] got=%b want=0", i, bus.in_ready);
      end
      cyc();
      checks++;
      if (obs() !== exp_a) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, obs(), exp_a);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready got=%b want=1", bus.in_ready);
    end
    cyc();
    checks++;
    if (obs() !== exp_b) begin
      errors++; $display("FAIL release_capture got=%h want=%h", obs(), exp_b);
    end
    bus.in_valid = 1'b0;
    cyc();
    exp_b[77] = 1'b0;
    checks++;
    if (obs() !== exp_b) begin
      errors++; $display("FAIL no_duplicate got=%h want=%h", obs(), exp_b);
    end
  endtask

  task automatic test_illegal_x0();
    logic [77:0] exp;
    bus.in_valid = 1'b1; bus.instr = 32'h00000073;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF;
    cyc();
    exp = {1'b1, 6'h3F, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL ecall got=%h want=%h", obs(), exp);
    end
    bus.wb_en = 1'b0; bus.instr = 32'h000003B3;
    cyc();
    exp = {1'b1, 6'h09, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL x0_read got=%h want=%h", obs(), exp);
    end
  endtask

  task automatic test_decode();
    logic [77:0] exp;
    bus.in_valid = 1'b1; bus.instr = 32'h4030D413;
    cyc();
    exp = {1'b1, 6'h08, 32'h10, 32'd3, 5'd8, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL srai got=%h want=%h", obs(), exp);
    end
    bus.instr = 32'h40009093;
    cyc();
    exp = {1'b1, 6'h3F, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL slli_bad_f7 got=%h want=%h", obs(), exp);
    end
    bus.instr = 32'h02208233;
    cyc();
    exp = {1'b1, 6'h3F, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL op_bad_f7 got=%h want=%h", obs(), exp);
    end
    bus.instr = 32'hFFF13513;
    cyc();
    exp = {1'b1, 6'h02, 32'd3, 32'hFFFFFFFF, 5'd10, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL sltiu got=%h want=%h", obs(), exp);
    end
  endtask

  task automatic test_reset_midflight();
    logic [77:0] exp;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid got=%b want=1", bus.out_valid);
    end
    reset = 1'b1; bus.in_valid = 1'b1; bus.instr = 32'h002084B3;
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h55;
    cyc();
    exp = '0;
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL midflight_reset got=%h want=%h", obs(), exp);
    end
    reset = 1'b0; bus.wb_en = 1'b0;
    cyc();
    exp = {1'b1, 6'h09, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0};
    checks++;
    if (obs() !== exp) begin
      errors++; $display("FAIL regs_cleared got=%h want=%h", obs(), exp);
    end
    bus.in_valid = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_bypass();
    test_back_to_back();
    test_illegal_x0();
    test_decode();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
